mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Bus-side responder for the processor's memory port: decodes each address
//   from the core and serves it from a word-wide synchronous RAM or from a
//   small MMIO block (LED register, free-running timer, compare/status).
//   Sits between cpu and on-chip memory; one responder per core port.
//   Read data returns after a fixed latency; writes complete in one cycle.
// PARAMETERS
//   RAM_WORDS   4096     RAM depth in 16-bit words (byte span = 2*RAM_WORDS)
//   MMIO_BASE   16'hF000 base byte address of the MMIO register window
//   RD_LATENCY  1        read latency in cycles; legal values 1 or 2
//   LED_W       10       width of the LED output register
// PORTS
//   clk            in   1       system clock, all logic on rising edge
//   reset          in   1       synchronous, active-high reset
//   i_mem_addr     in   16      byte address from core; bit 0 ignored
//   i_mem_rd       in   1       read strobe, one request per asserted cycle
//   i_mem_wr       in   1       write strobe, one request per asserted cycle
//   i_mem_wrdata   in   16      write data, sampled with i_mem_wr
//   o_mem_rddata   out  16      read data, valid RD_LATENCY cycles after i_mem_rd
//   o_rddata_valid out  1       one-cycle pulse marking o_mem_rddata update
//   o_led          out  LED_W   LED register contents
//   o_irq          out  1       timer compare-match sticky flag
// BEHAVIOUR
//   Decode (word index = addr[15:1]):
//   - addr < 2*RAM_WORDS: RAM word addr[15:1].
//   - MMIO_BASE+0 LED (R/W, low LED_W bits; upper bits read 0).
//   - MMIO_BASE+2 TIMER (R/W; write loads value).
//   - MMIO_BASE+4 CMP (R/W).
//   - MMIO_BASE+6 STATUS (bit0 = match flag; write 1 to bit0 clears; others read 0).
//   - Anything else: read returns 16'h0000; write ignored, no side effect.
//   Reads:
//   - Address and decode select are registered on the i_mem_rd cycle N.
//   - o_mem_rddata and o_rddata_valid update at edge N+RD_LATENCY.
//   - With RD_LATENCY=2, data passes through one extra output register stage.
//   - Back-to-back reads every cycle are supported and stay fully pipelined.
//   - o_mem_rddata holds its last value until the next read returns.
//   - MMIO reads return the register value as of the end of cycle N.
//   Writes:
//   - A write takes effect at the edge ending the i_mem_wr cycle.
//   - A read issued in the next cycle returns the new value.
//   Simultaneous rd+wr, same address:
//   - The read returns the old value (read-before-write).
//   - The write still commits.
//   Timer:
//   - Increments by 1 every cycle and wraps 16'hFFFF->16'h0000.
//   - A write to TIMER overrides the increment in that cycle.
//   Match:
//   - When TIMER==CMP at a rising edge, the flag sets and stays set.
//   - Set wins over a same-cycle write-1-to-clear.
//   - o_irq is the flag output, registered.
//   Reset (synchronous, takes priority over everything):
//   - o_mem_rddata=0, o_rddata_valid=0, o_led=0, TIMER=0, CMP=16'hFFFF, flag=0.
//   - The read pipeline is flushed: a read in flight at reset produces no
//     valid pulse.
//   - RAM contents are not cleared.
// TESTING
//   1. wr 0x0010<=16'hBEEF, then rd 0x0010 -> rddata 16'hBEEF, valid pulse
//      exactly RD_LATENCY cycles after rd.
//   2. rd 0x0011 after scenario 1 -> 16'hBEEF (bit 0 ignored).
//      rd 0xE000 (unmapped) -> 16'h0000.
//   3. rd 0x0000, 0x0002, 0x0004 on consecutive cycles, preloaded 1,2,3 ->
//      1,2,3 on consecutive cycles, valid high 3 cycles.
//   4. wr LED<=16'hFFFF -> o_led=10'h3FF; rd LED -> 16'h03FF.
//   5. wr CMP<=5, wr TIMER<=0 -> o_irq rises 5 cycles after the TIMER write
//      edge; wr STATUS<=1 clears it; a clear issued in the match cycle leaves
//      it set.
//   6. Assert reset mid read with RD_LATENCY=2 -> no valid pulse, rddata=0,
//      o_led=0; RAM word written before reset still reads back intact.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-port responder: decodes core addresses into a word RAM or a small MMIO block
// (LED, free-running timer, compare/status) and returns read data after RD_LATENCY cycles.
module mem_responder #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter logic [15:0] MMIO_BASE  = 16'hF000,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned LED_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      i_mem_addr,
  input  logic             i_mem_rd,
  input  logic             i_mem_wr,
  input  logic [15:0]      i_mem_wrdata,
  output logic [15:0]      o_mem_rddata,
  output logic             o_rddata_valid,
  output logic [LED_W-1:0] o_led,
  output logic             o_irq
);

  localparam int unsigned RamAw    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [14:0] MmioWord = MMIO_BASE[15:1];

  logic [14:0]      word_idx;
  logic [RamAw-1:0] ram_idx;
  logic             unused_addr_bit;
  logic             sel_ram, sel_led, sel_timer, sel_cmp, sel_status;

  assign word_idx        = i_mem_addr[15:1];
  assign ram_idx         = word_idx[RamAw-1:0];
  assign unused_addr_bit = i_mem_addr[0];

  always_comb begin
    sel_ram    = ({17'd0, word_idx} < RAM_WORDS);
    sel_led    = !sel_ram && (word_idx == MmioWord);
    sel_timer  = !sel_ram && (word_idx == MmioWord + 15'd1);
    sel_cmp    = !sel_ram && (word_idx == MmioWord + 15'd2);
    sel_status = !sel_ram && (word_idx == MmioWord + 15'd3);
  end

  logic [LED_W-1:0] led_q, led_d;
  logic [15:0]      timer_q, timer_d;
  logic [15:0]      cmp_q, cmp_d;
  logic             flag_q, flag_d;
  logic [15:0]      mmio_rd;

  always_comb begin
    led_d   = led_q;
    cmp_d   = cmp_q;
    timer_d = timer_q + 16'd1;
    if (i_mem_wr && sel_led)   led_d   = i_mem_wrdata[LED_W-1:0];
    if (i_mem_wr && sel_timer) timer_d = i_mem_wrdata;
    if (i_mem_wr && sel_cmp)   cmp_d   = i_mem_wrdata;
    // A match at this edge beats a same-cycle write-1-to-clear.
    flag_d = (timer_d == cmp_q) ||
             (flag_q && !(i_mem_wr && sel_status && i_mem_wrdata[0]));
  end

  always_comb begin
    mmio_rd = '0;
    if (sel_led)         mmio_rd = 16'(led_q);
    else if (sel_timer)  mmio_rd = timer_q;
    else if (sel_cmp)    mmio_rd = cmp_q;
    else if (sel_status) mmio_rd = {15'd0, flag_q};
  end

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] ram_rd_q;
  logic [15:0] mmio_rd_q;
  logic        rd_sel_ram_q;
  logic        rd_valid_q;
  logic [15:0] stage_data;

  // Read and write in one block so a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (i_mem_rd) ram_rd_q <= ram[ram_idx];
    if (!reset && i_mem_wr && sel_ram) ram[ram_idx] <= i_mem_wrdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q        <= '0;
      timer_q      <= '0;
      cmp_q        <= 16'hFFFF;
      flag_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_sel_ram_q <= 1'b0;
      mmio_rd_q    <= '0;
    end else begin
      led_q      <= led_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      flag_q     <= flag_d;
      rd_valid_q <= i_mem_rd;
      if (i_mem_rd) begin
        rd_sel_ram_q <= sel_ram;
        mmio_rd_q    <= mmio_rd;
      end
    end
  end

  assign stage_data = rd_sel_ram_q ? ram_rd_q : mmio_rd_q;

  if (RD_LATENCY == 2) begin : g_lat2
    logic [15:0] out_q;
    logic        out_valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) out_q <= stage_data;
      end
    end

    assign o_mem_rddata   = out_q;
    assign o_rddata_valid = out_valid_q;
  end else begin : g_lat1
    assign o_mem_rddata   = stage_data;
    assign o_rddata_valid = rd_valid_q;
  end

  assign o_led = led_q;
  assign o_irq = flag_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one latency-1 and one latency-2 instance share directed
// stimulus; a transaction-level model is compared every cycle, plus literal checks.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] rd1, rd2;
  logic        v1, v2;
  logic [9:0]  led1, led2;
  logic        irq1, irq2;

  mem_responder #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .i_mem_addr(addr), .i_mem_rd(rd), .i_mem_wr(wr),
    .i_mem_wrdata(wdata), .o_mem_rddata(rd1), .o_rddata_valid(v1), .o_led(led1), .o_irq(irq1)
  );

  mem_responder #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .i_mem_addr(addr), .i_mem_rd(rd), .i_mem_wr(wr),
    .i_mem_wrdata(wdata), .o_mem_rddata(rd2), .o_rddata_valid(v2), .o_led(led2), .o_irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory map as arrays/variables, read results as delayed copies.
  logic [15:0] ram_m [4096];
  logic [9:0]  m_led;
  logic [15:0] m_timer, m_cmp;
  logic        m_flag;
  logic [15:0] e1_d, s2_d, e2_d;
  logic        e1_v, s2_v, e2_v;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int unsigned w = int'(a) / 2;
    if (w < 4096)     return ram_m[w];
    if (w == 16'hF000 / 2) return {6'd0, m_led};
    if (w == 16'hF002 / 2) return m_timer;
    if (w == 16'hF004 / 2) return m_cmp;
    if (w == 16'hF006 / 2) return {15'd0, m_flag};
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    logic [15:0] rv, nt, nc;
    logic        clr;
    int unsigned w;
    if (reset) begin
      m_led = '0; m_timer = '0; m_cmp = 16'hFFFF; m_flag = 1'b0;
      e1_d = '0; e1_v = 1'b0; s2_d = '0; s2_v = 1'b0; e2_d = '0; e2_v = 1'b0;
    end else begin
      rv = model_read(addr);
      e2_v = s2_v;
      if (s2_v) e2_d = s2_d;
      s2_v = rd;
      if (rd) s2_d = rv;
      e1_v = rd;
      if (rd) e1_d = rv;
      nt  = m_timer + 16'd1;
      nc  = m_cmp;
      clr = 1'b0;
      w   = int'(addr) / 2;
      if (wr) begin
        if (w < 4096)               ram_m[w] = wdata;
        else if (w == 16'hF000 / 2) m_led = wdata[9:0];
        else if (w == 16'hF002 / 2) nt = wdata;
        else if (w == 16'hF004 / 2) nc = wdata;
        else if (w == 16'hF006 / 2) clr = wdata[0];
      end
      m_flag  = (nt == m_cmp) || (m_flag && !clr);
      m_timer = nt;
      m_cmp   = nc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rddata_lat1", rd1, e1_d);
      chk("valid_lat1", {15'd0, v1}, {15'd0, e1_v});
      chk("rddata_lat2", rd2, e2_d);
      chk("valid_lat2", {15'd0, v2}, {15'd0, e2_v});
      chk("led", {6'd0, led1}, {6'd0, m_led});
      chk("led_lat2", {6'd0, led2}, {6'd0, m_led});
      chk("irq", {15'd0, irq1}, {15'd0, m_flag});
      chk("irq_lat2", {15'd0, irq2}, {15'd0, m_flag});
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_rddata", rd1, 16'h0000);
    chk("reset_led", {6'd0, led1}, 16'h0000);

    cyc(1'b1, 1'b0, 16'hF004, 16'h0);
    chk("cmp_reset_val", rd1, 16'hFFFF);

    // write then read, latency 1 and 2
    cyc(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0);
    chk("beef_lat1", rd1, 16'hBEEF);
    chk("beef_v1", {15'd0, v1}, 16'h1);
    chk("beef_v2_early", {15'd0, v2}, 16'h0);
    idle();
    chk("beef_lat2", rd2, 16'hBEEF);
    chk("beef_v2", {15'd0, v2}, 16'h1);
    chk("v1_pulse_end", {15'd0, v1}, 16'h0);
    chk("rd1_hold", rd1, 16'hBEEF);

    // odd address, unmapped read/write
    cyc(1'b1, 1'b0, 16'h0011, 16'h0);
    chk("odd_addr", rd1, 16'hBEEF);
    cyc(1'b0, 1'b1, 16'hE000, 16'h1234);
    cyc(1'b1, 1'b0, 16'hE000, 16'h0);
    chk("unmapped", rd1, 16'h0000);
    cyc(1'b1, 1'b0, 16'hF008, 16'h0);
    chk("unmapped_mmio", rd1, 16'h0000);

    // back-to-back reads
    cyc(1'b0, 1'b1, 16'h0000, 16'd1);
    cyc(1'b0, 1'b1, 16'h0002, 16'd2);
    cyc(1'b0, 1'b1, 16'h0004, 16'd3);
    cyc(1'b1, 1'b0, 16'h0000, 16'h0);
    chk("b2b_0", rd1, 16'd1);
    cyc(1'b1, 1'b0, 16'h0002, 16'h0);
    chk("b2b_1", rd1, 16'd2);
    chk("b2b_1_lat2", rd2, 16'd1);
    cyc(1'b1, 1'b0, 16'h0004, 16'h0);
    chk("b2b_2", rd1, 16'd3);
    chk("b2b_v", {15'd0, v1}, 16'h1);
    idle();
    chk("b2b_2_lat2", rd2, 16'd3);

    // read-before-write on same address
    cyc(1'b1, 1'b1, 16'h0002, 16'h5555);
    chk("rbw_old", rd1, 16'd2);
    cyc(1'b1, 1'b0, 16'h0002, 16'h0);
    chk("rbw_new", rd1, 16'h5555);

    // LED
    cyc(1'b0, 1'b1, 16'hF000, 16'hFFFF);
    chk("led_write", {6'd0, led1}, 16'h03FF);
    cyc(1'b1, 1'b0, 16'hF000, 16'h0);
    chk("led_read", rd1, 16'h03FF);

    // timer and compare match
    cyc(1'b0, 1'b1, 16'hF004, 16'd5);
    cyc(1'b0, 1'b1, 16'hF002, 16'd0);
    repeat (4) idle();
    chk("irq_before", {15'd0, irq1}, 16'h0);
    idle();
    chk("irq_rise", {15'd0, irq1}, 16'h1);
    cyc(1'b1, 1'b0, 16'hF006, 16'h0);
    chk("status_read", rd1, 16'h0001);
    cyc(1'b0, 1'b1, 16'hF006, 16'h0001);
    chk("irq_clear", {15'd0, irq1}, 16'h0);
    cyc(1'b0, 1'b1, 16'hF002, 16'd0);
    repeat (4) idle();
    cyc(1'b0, 1'b1, 16'hF006, 16'h0001);
    chk("set_beats_clr", {15'd0, irq1}, 16'h1);
    cyc(1'b0, 1'b1, 16'hF002, 16'h1234);
    cyc(1'b1, 1'b0, 16'hF002, 16'h0);
    chk("timer_load", rd1, 16'h1234);
    cyc(1'b1, 1'b0, 16'hF002, 16'h0);
    chk("timer_inc", rd1, 16'h1235);

    // reset with a latency-2 read in flight
    cyc(1'b0, 1'b1, 16'h0100, 16'hA5A5);
    cyc(1'b1, 1'b0, 16'h0100, 16'h0);
    reset = 1'b1;
    idle();
    chk("rst_v2", {15'd0, v2}, 16'h0);
    chk("rst_rd2", rd2, 16'h0000);
    chk("rst_led", {6'd0, led1}, 16'h0000);
    chk("rst_irq", {15'd0, irq1}, 16'h0);
    reset = 1'b0;
    idle();
    chk("rst_no_pulse", {15'd0, v2}, 16'h0);
    cyc(1'b1, 1'b0, 16'h0100, 16'h0);
    idle();
    chk("ram_kept", rd2, 16'hA5A5);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
